// File: rtl/lap_recall_ctrl.sv
// lap_recall_ctrl: sequencing controller for the stopwatch datapath.
//   Drives the timer enable and the display-counter clear, captures split
//   (lap) times into a DEPTH-entry buffer, and picks what the display shows:
//   live time, a frozen lap for HOLD_TICKS ticks, or a blinking recall view.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start_i/stop_i/split_i  debounced single-cycle command pulses
//   tick_i              250 ms display-rate enable
//   time_i              live packed BCD time from the display counter
//   run_o               timer count enable
//   clear_o             one-cycle display-counter clear
//   disp_time_o         registered time to display
//   live_o / blank_o    display tracks time_i / display blanked
//   lap_idx_o           lap shown in recall (0 otherwise)
//   lap_count_o         laps stored
//   full_o              sticky: split attempted with buffer full
module lap_recall_ctrl #(
  parameter int DEPTH      = 8,
  parameter int HOLD_TICKS = 8,
  parameter int TIME_W     = 32,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1,
  localparam int HW        = $clog2(HOLD_TICKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              split_i,
  input  logic              tick_i,
  input  logic [TIME_W-1:0] time_i,
  output logic              run_o,
  output logic              clear_o,
  output logic [TIME_W-1:0] disp_time_o,
  output logic              live_o,
  output logic              blank_o,
  output logic [AW-1:0]     lap_idx_o,
  output logic [CW-1:0]     lap_count_o,
  output logic              full_o
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_HOLD, S_STOPPED, S_RECALL} state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              full_q, full_d;
  logic              run_q, run_d;
  logic              clear_q, clear_d;
  logic              live_q, live_d;
  logic              blank_q, blank_d;
  logic [TIME_W-1:0] disp_q, disp_d;
  logic [TIME_W-1:0] lap_q [DEPTH];

  // Coincident pulses: stop beats start beats split; losers are dropped.
  logic stp, sta, spl;
  assign stp = stop_i;
  assign sta = start_i & ~stop_i;
  assign spl = split_i & ~start_i & ~stop_i;

  logic cap;  // split accepted in RUN/HOLD: freeze display at time_i
  logic wr;   // capture actually stored (buffer not full)

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    full_d  = full_q;
    clear_d = 1'b0;
    cap     = 1'b0;
    wr      = 1'b0;
    case (state_q)
      S_IDLE: if (sta) state_d = S_RUN;
      S_RUN, S_HOLD: begin
        if (stp) begin
          state_d = S_STOPPED;
        end else if (spl) begin
          cap     = 1'b1;
          state_d = S_HOLD;
          hold_d  = HW'(HOLD_TICKS);
          if (cnt_q < CW'(DEPTH)) begin
            wr    = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            full_d = 1'b1;
          end
        end else if (state_q == S_HOLD && tick_i) begin
          if (hold_q == HW'(1)) state_d = S_RUN;
          hold_d = hold_q - 1'b1;
        end
      end
      S_STOPPED: begin
        if (stp) begin
          clear_d = 1'b1;
          cnt_d   = '0;
          full_d  = 1'b0;
          state_d = S_IDLE;
        end else if (sta) begin
          state_d = S_RUN;
        end else if (spl && cnt_q != '0) begin
          state_d = S_RECALL;
          idx_d   = '0;
        end
      end
      S_RECALL: begin
        if (stp) begin
          state_d = S_STOPPED;
          idx_d   = '0;
        end else if (sta) begin
          state_d = S_RUN;
          idx_d   = '0;
        end else if (spl) begin
          // Wrap after the last stored lap, not after DEPTH-1.
          idx_d = ({1'b0, idx_q} == cnt_q - 1'b1) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-state derived from the next FSM state so every output is
  // registered and moves one cycle after its cause.
  always_comb begin
    run_d   = (state_d == S_RUN) || (state_d == S_HOLD);
    live_d  = !((state_d == S_HOLD) || (state_d == S_RECALL));
    // Blink only while staying in recall; entering or leaving forces unblanked.
    blank_d = (state_q == S_RECALL && state_d == S_RECALL) ? (blank_q ^ tick_i) : 1'b0;
    case (state_d)
      S_HOLD:   disp_d = cap ? time_i : disp_q;
      S_RECALL: disp_d = lap_q[idx_d];
      default:  disp_d = time_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      full_q  <= 1'b0;
      run_q   <= 1'b0;
      clear_q <= 1'b0;
      live_q  <= 1'b1;
      blank_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
      run_q   <= run_d;
      clear_q <= clear_d;
      live_q  <= live_d;
      blank_q <= blank_d;
      disp_q  <= disp_d;
    end
  end

  // Lap storage needs no reset; lap_count gates which entries are valid.
  always_ff @(posedge clk) begin
    if (wr) lap_q[cnt_q[AW-1:0]] <= time_i;
  end

  assign run_o       = run_q;
  assign clear_o     = clear_q;
  assign disp_time_o = disp_q;
  assign live_o      = live_q;
  assign blank_o     = blank_q;
  assign lap_idx_o   = idx_q;
  assign lap_count_o = cnt_q;
  assign full_o      = full_q;

endmodule

// File: tb/tb_lap_recall_ctrl.sv
module tb_lap_recall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, stop_i, split_i, tick_i;
  logic [31:0] time_i;
  logic        run_o, clear_o, live_o, blank_o, full_o;
  logic [31:0] disp_time_o;
  logic [2:0]  lap_idx_o;
  logic [3:0]  lap_count_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lap_recall_ctrl dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .stop_i(stop_i), .split_i(split_i), .tick_i(tick_i),
    .time_i(time_i),
    .run_o(run_o), .clear_o(clear_o), .disp_time_o(disp_time_o),
    .live_o(live_o), .blank_o(blank_o), .lap_idx_o(lap_idx_o),
    .lap_count_o(lap_count_o), .full_o(full_o)
  );

  typedef struct packed {
    logic        run;
    logic        clr;
    logic [31:0] disp;
    logic        live;
    logic        blank;
    logic [2:0]  idx;
    logic [3:0]  cnt;
    logic        full;
  } out_t;

  typedef struct packed {
    logic        st, sp, sl, tk;
    logic [31:0] tm;
    out_t        exp;
  } vec_t;

  function automatic out_t act();
    return '{run_o, clear_o, disp_time_o, live_o, blank_o, lap_idx_o, lap_count_o, full_o};
  endfunction

  task automatic chk_out(input string name, input out_t exp);
    out_t a;
    a = act();
    checks++;
    if (a !== exp) begin
      failures++;
      $display("FAIL %s: got run=%0b clr=%0b disp=%h live=%0b blank=%0b idx=%0d cnt=%0d full=%0b want run=%0b clr=%0b disp=%h live=%0b blank=%0b idx=%0d cnt=%0d full=%0b",
               name, a.run, a.clr, a.disp, a.live, a.blank, a.idx, a.cnt, a.full,
               exp.run, exp.clr, exp.disp, exp.live, exp.blank, exp.idx, exp.cnt, exp.full);
    end
  endtask

  // Drive one cycle of inputs at negedge; outputs are examined at the next
  // negedge, i.e. after exactly one rising edge.
  task automatic cyc(input logic st, sp, sl, tk, input logic [31:0] tm);
    start_i = st; stop_i = sp; split_i = sl; tick_i = tk; time_i = tm;
    @(negedge clk);
    start_i = 0; stop_i = 0; split_i = 0; tick_i = 0;
  endtask

  vec_t vt [21];
  logic [31:0] lap [8];

  initial begin
    //             st sp sl tk time          run clr disp          live blk idx cnt full
    vt[0]  = '{0,0,0,0,32'h11,   '{0,0,32'h11,   1,0,0,0,0}};
    vt[1]  = '{1,0,0,0,32'h12,   '{1,0,32'h12,   1,0,0,0,0}};
    vt[2]  = '{0,0,0,0,32'h13,   '{1,0,32'h13,   1,0,0,0,0}};
    vt[3]  = '{0,0,1,0,32'h1234, '{1,0,32'h1234, 0,0,0,1,0}};
    vt[4]  = '{0,0,0,1,32'h1300, '{1,0,32'h1234, 0,0,0,1,0}};
    vt[5]  = '{0,0,1,0,32'h2000, '{1,0,32'h2000, 0,0,0,2,0}};
    vt[6]  = '{0,1,0,0,32'h2100, '{0,0,32'h2100, 1,0,0,2,0}};
    vt[7]  = '{0,0,1,0,32'h2200, '{0,0,32'h1234, 0,0,0,2,0}};
    vt[8]  = '{0,0,0,1,32'h2300, '{0,0,32'h1234, 0,1,0,2,0}};
    vt[9]  = '{0,0,1,0,32'h2400, '{0,0,32'h2000, 0,1,1,2,0}};
    vt[10] = '{0,0,1,0,32'h2500, '{0,0,32'h1234, 0,1,0,2,0}};
    vt[11] = '{0,0,0,1,32'h2600, '{0,0,32'h1234, 0,0,0,2,0}};
    vt[12] = '{0,0,1,1,32'h2700, '{0,0,32'h2000, 0,1,1,2,0}};
    vt[13] = '{0,1,0,0,32'h3000, '{0,0,32'h3000, 1,0,0,2,0}};
    vt[14] = '{1,0,0,0,32'h3100, '{1,0,32'h3100, 1,0,0,2,0}};
    vt[15] = '{1,1,0,0,32'h3200, '{0,0,32'h3200, 1,0,0,2,0}};
    vt[16] = '{0,1,0,0,32'h3300, '{0,1,32'h3300, 1,0,0,0,0}};
    vt[17] = '{0,0,0,0,32'h3400, '{0,0,32'h3400, 1,0,0,0,0}};
    vt[18] = '{0,1,1,0,32'h3500, '{0,0,32'h3500, 1,0,0,0,0}};
    vt[19] = '{1,0,1,0,32'h3600, '{1,0,32'h3600, 1,0,0,0,0}};
    vt[20] = '{0,0,0,1,32'h3700, '{1,0,32'h3700, 1,0,0,0,0}};

    rst = 1'b0; start_i = 0; stop_i = 0; split_i = 0; tick_i = 0; time_i = 32'h99;
    repeat (2) @(negedge clk);
    chk_out("reset", '{0,0,32'h0,1,0,0,0,0});
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cyc(vt[i].st, vt[i].sp, vt[i].sl, vt[i].tk, vt[i].tm);
      chk_out($sformatf("vec%0d", i), vt[i].exp);
    end

    // Hold expiry: display frozen for 7 ticks, live again on the 8th.
    cyc(0,0,1,0,32'h1234);
    chk_out("hold_cap", '{1,0,32'h1234,0,0,0,1,0});
    for (int i = 1; i <= 7; i++) begin
      cyc(0,0,0,1,32'h5000 + i);
      chk_out($sformatf("hold_tick%0d", i), '{1,0,32'h1234,0,0,0,1,0});
    end
    cyc(0,0,0,1,32'h5008);
    chk_out("hold_expire", '{1,0,32'h5008,1,0,0,1,0});
    cyc(0,0,0,0,32'h6000);
    chk_out("live_track", '{1,0,32'h6000,1,0,0,1,0});

    // Fill the buffer and overflow it; the overflowing split still freezes.
    lap[0] = 32'h1234;
    for (int k = 1; k <= 8; k++) begin
      cyc(0,0,1,0,32'h100 + k);
      if (k < 8) lap[k] = 32'h100 + k;
      chk_out($sformatf("fill%0d", k),
              '{1,0,32'h100 + k,0,0,0,(k + 1 > 8) ? 4'd8 : 4'(k + 1),(k == 8)});
    end
    cyc(0,1,0,0,32'h7000);
    chk_out("stop_full", '{0,0,32'h7000,1,0,0,8,1});

    // Recall across all 8 laps with wrap.
    cyc(0,0,1,0,32'h7100);
    chk_out("recall0", '{0,0,lap[0],0,0,0,8,1});
    for (int j = 1; j <= 8; j++) begin
      cyc(0,0,1,0,32'h7100);
      chk_out($sformatf("recall_step%0d", j), '{0,0,lap[j % 8],0,0,3'(j % 8),8,1});
    end
    cyc(0,1,0,0,32'h7200);
    chk_out("recall_stop", '{0,0,32'h7200,1,0,0,8,1});
    cyc(0,1,0,0,32'h7300);
    chk_out("clear", '{0,1,32'h7300,1,0,0,0,0});
    cyc(0,0,0,0,32'h7400);
    chk_out("clear_done", '{0,0,32'h7400,1,0,0,0,0});

    // Asynchronous reset in the middle of HOLD, checked before any clock edge.
    cyc(1,0,0,0,32'h8000);
    cyc(0,0,1,0,32'h8100);
    chk_out("pre_reset_hold", '{1,0,32'h8100,0,0,0,1,0});
    #2 rst = 1'b0;
    #1 chk_out("async_reset", '{0,0,32'h0,1,0,0,0,0});
    @(negedge clk);
    rst = 1'b1;
    cyc(0,0,0,1,32'h8200);
    chk_out("after_reset", '{0,0,32'h8200,1,0,0,0,0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lap_recall_ctrl.md
Name: lap_recall_ctrl

Overview:
- Sequencing controller for the stopwatch datapath; replaces the simple start/stop/split FSM.
- Drives the timer enable and the display-counter clear.
- Captures split (lap) times into an internal DEPTH-entry buffer.
- Selects what the 7-segment path shows: live time, a frozen lap for a hold period, or a blinking recall view stepping through stored laps.

Parameters:
- DEPTH, 8: number of lap entries stored; power of two, ≥2.
- HOLD_TICKS, 8: tick_i pulses a split stays frozen on display (8 × 250 ms = 2 s).
- TIME_W, 32: packed time width, 8 BCD digits {HOUR1,HOUR0,MIN1,MIN0,SEG1,SEG0,CSEG1,CSEG0}.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  debounced single-cycle start pulse.
- stop_i  in  1  debounced single-cycle stop pulse.
- split_i  in  1  debounced single-cycle split pulse.
- tick_i  in  1  single-cycle display-rate enable (250 ms).
- time_i  in  TIME_W  live time from display counter.
- run_o  out  1  timer count enable.
- clear_o  out  1  one-cycle pulse: clear display counter to 00:00:00.00.
- disp_time_o  out  TIME_W  time to display (registered).
- live_o  out  1  1 = disp_time_o tracks time_i.
- blank_o  out  1  1 = display blanked (recall blink phase).
- lap_idx_o  out  log2(DEPTH)  lap index shown in RECALL, else 0.
- lap_count_o  out  log2(DEPTH)+1  laps stored.
- full_o  out  1  sticky: split attempted with buffer full.

Behaviour:
- Reset (rst=0, async): state IDLE; run_o=0, clear_o=0, disp_time_o=0, live_o=1, blank_o=0, lap_idx_o=0, lap_count_o=0, full_o=0, hold counter=0. Buffer contents don't-care.
- All state, outputs and buffer update on rising clk. Every output is registered, so a change appears 1 cycle after the causing input.
- Input priority when pulses coincide: stop_i > start_i > split_i; lower-priority pulses in that cycle are dropped.
- IDLE:
  - start_i -> RUN.
  - stop_i and split_i ignored.
- RUN (run_o=1, live):
  - stop_i -> STOPPED.
  - split_i:
    - if lap_count<DEPTH: write time_i to buf[lap_count], lap_count+1.
    - else: no write, full_o<=1.
    - In both cases: disp_time_o<=time_i (the same-cycle value), live_o<=0, hold<=HOLD_TICKS, -> HOLD.
- HOLD (run_o=1, display frozen):
  - tick_i decrements hold; tick_i when hold==1 -> RUN, live_o<=1.
  - split_i: same capture rules as in RUN; hold reloads to HOLD_TICKS.
  - stop_i -> STOPPED, live_o<=1.
- STOPPED (run_o=0, live_o=1):
  - start_i -> RUN (resume, no clear).
  - split_i with lap_count>0 -> RECALL, lap_idx_o=0.
  - split_i with lap_count==0: ignored.
  - stop_i -> clear: clear_o=1 for exactly 1 cycle, lap_count<=0, full_o<=0, -> IDLE.
- RECALL (run_o=0, live_o=0):
  - disp_time_o=buf[lap_idx_o].
  - tick_i toggles blank_o.
  - split_i: lap_idx_o+1, wrapping to 0 after lap_count-1.
  - start_i: blank_o<=0, lap_idx_o<=0, live_o<=1, -> RUN.
  - stop_i: blank_o<=0, lap_idx_o<=0, live_o<=1, -> STOPPED.
- Live states (IDLE, RUN, STOPPED): disp_time_o<=time_i every cycle (1-cycle latency).
- tick_i has no effect outside HOLD and RECALL.
- Async reset mid-operation: immediate return to reset values; run_o drops without waiting for clk.

Test Plan:
- Reset, start_i, run 10 cycles, stop_i -> run_o 0→1 one cycle after start, 1→0 one cycle after stop; state STOPPED; clear_o stays 0.
- RUN, time_i=0x00001234, split_i -> buf[0]=0x00001234, lap_count_o=1, live_o=0, disp_time_o holds 0x00001234 for 8 tick_i, then live_o=1 and tracks time_i.
- 9 splits with DEPTH=8 -> lap_count_o=8, full_o=1 after the 9th; the 9th still freezes the display.
- STOPPED with 3 laps, split_i ×4 -> lap_idx_o 0,1,2,0; disp_time_o equals the matching stored values; blank_o toggles on each tick_i.
- STOPPED, then stop_i -> clear_o high exactly 1 cycle, lap_count_o=0, full_o=0, state IDLE.
- start_i+stop_i in the same cycle while RUN -> STOPPED (stop wins); rst low mid-HOLD -> all outputs reset values asynchronously.
